// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of a single-port SDRAM controller.
// Serialises accesses, shapes rd/we edges and returns data plus ack.
module sdram_port_arbiter #(
  parameter int RD_LATENCY  = 16,
  parameter int WR_TIMEOUT  = 64,
  parameter int P0_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  req,
  input  logic [2:0]  req_we,
  input  logic [68:0] req_addr,
  input  logic [47:0] req_din,
  input  logic [5:0]  req_wtbt,
  output logic [2:0]  ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        wr_timeout,
  output logic [22:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_wtbt,
  output logic        sd_we,
  output logic        sd_rd,
  input  logic [15:0] sd_dout,
  input  logic        sd_ready
);

  typedef enum logic [2:0] {
    BOOT, IDLE, RD_WAIT, WR_WAIT, RELEASE
  } state_e;

  localparam logic [7:0] RD_LAST = 8'(RD_LATENCY - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        seen_low_q, seen_low_d;
  logic [2:0]  ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        wr_to_q, wr_to_d;
  logic [22:0] sd_addr_q, sd_addr_d;
  logic [15:0] sd_din_q, sd_din_d;
  logic [1:0]  sd_wtbt_q, sd_wtbt_d;
  logic        sd_we_q, sd_we_d;
  logic        sd_rd_q, sd_rd_d;

  logic [1:0]  win;
  logic [22:0] sel_addr;
  logic [15:0] sel_din;
  logic [1:0]  sel_wtbt;
  logic        sel_we;

  // Round-robin search starts at the port after the last grant
  always_comb begin
    win = 2'd0;
    case (last_q)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    if (P0_PRIORITY != 0 && req[0])
      win = 2'd0;
  end

  always_comb begin
    sel_addr = req_addr[22:0];
    sel_din  = req_din[15:0];
    sel_wtbt = req_wtbt[1:0];
    sel_we   = req_we[0];
    case (win)
      2'd1: begin
        sel_addr = req_addr[45:23];
        sel_din  = req_din[31:16];
        sel_wtbt = req_wtbt[3:2];
        sel_we   = req_we[1];
      end
      2'd2: begin
        sel_addr = req_addr[68:46];
        sel_din  = req_din[47:32];
        sel_wtbt = req_wtbt[5:4];
        sel_we   = req_we[2];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    seen_low_d = seen_low_q;
    ack_d      = 3'b000;
    rdata_d    = rdata_q;
    wr_to_d    = 1'b0;
    sd_addr_d  = sd_addr_q;
    sd_din_d   = sd_din_q;
    sd_wtbt_d  = sd_wtbt_q;
    sd_we_d    = sd_we_q;
    sd_rd_d    = sd_rd_q;
    unique case (state_q)
      BOOT: begin
        if (sd_ready)
          state_d = IDLE;
      end
      IDLE: begin
        if (|req) begin
          gnt_d      = win;
          last_d     = win;
          sd_addr_d  = sel_addr;
          sd_din_d   = sel_din;
          sd_wtbt_d  = sel_wtbt;
          cnt_d      = 8'd0;
          seen_low_d = 1'b0;
          if (sel_we) begin
            sd_we_d = 1'b1;
            state_d = WR_WAIT;
          end else begin
            sd_rd_d = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == RD_LAST) begin
          rdata_d = sd_dout;
          ack_d   = 3'b001 << gnt_q;
          sd_rd_d = 1'b0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR_WAIT: begin
        seen_low_d = seen_low_q | ~sd_ready;
        // Ready must be seen low first so a stale high is not taken as done
        if (seen_low_q && sd_ready) begin
          ack_d   = 3'b001 << gnt_q;
          sd_we_d = 1'b0;
          state_d = RELEASE;
        end else if (cnt_q == WR_LAST) begin
          ack_d   = 3'b001 << gnt_q;
          wr_to_d = 1'b1;
          sd_we_d = 1'b0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: state_d = BOOT;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      last_q     <= 2'd2;
      gnt_q      <= 2'd0;
      cnt_q      <= 8'd0;
      seen_low_q <= 1'b0;
      ack_q      <= 3'b000;
      rdata_q    <= 16'h0000;
      busy_q     <= 1'b0;
      wr_to_q    <= 1'b0;
      sd_addr_q  <= 23'h0;
      sd_din_q   <= 16'h0000;
      sd_wtbt_q  <= 2'b00;
      sd_we_q    <= 1'b0;
      sd_rd_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      wr_to_q    <= wr_to_d;
      sd_addr_q  <= sd_addr_d;
      sd_din_q   <= sd_din_d;
      sd_wtbt_q  <= sd_wtbt_d;
      sd_we_q    <= sd_we_d;
      sd_rd_q    <= sd_rd_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign wr_timeout = wr_to_q;
  assign sd_addr    = sd_addr_q;
  assign sd_din     = sd_din_q;
  assign sd_wtbt    = sd_wtbt_q;
  assign sd_we      = sd_we_q;
  assign sd_rd      = sd_rd_q;

endmodule
